// File: rtl/xosera_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : xosera_bus_bridge
//  Purpose  : Queues 16-bit CPU register accesses and replays them as timed
//             8-bit Xosera bus cycles (setup / strobe / hold per byte).
//  Revision : 1.0  initial release
// ============================================================================

module xosera_bus_bridge #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1,
   parameter int REG_W         = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_write,
   input  logic             cpu_byte,
   input  logic [REG_W-1:0] cpu_reg,
   input  logic [15:0]      cpu_wdata,
   output logic             cpu_busy,
   output logic [15:0]      cpu_rdata,
   output logic             cpu_rdata_valid,
   output logic             bus_cs_n,
   output logic             bus_rd_nwr,
   output logic [REG_W-1:0] bus_reg_num,
   output logic             bus_bytesel,
   output logic [7:0]       bus_data_o,
   input  logic [7:0]       bus_data_i
);

   localparam int c_AW      = $clog2(FIFO_DEPTH);
   localparam int c_MAX_SS  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int c_MAX_PH  = (c_MAX_SS > HOLD_CYCLES) ? c_MAX_SS : HOLD_CYCLES;
   localparam int c_CNT_W   = $clog2(c_MAX_PH + 1);
   localparam int c_ENT_W   = REG_W + 18;
   localparam int c_WR_BIT  = c_ENT_W - 1;
   localparam int c_BY_BIT  = c_ENT_W - 2;

   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_SETUP  = c_CNT_W'(SETUP_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_STROBE = c_CNT_W'(STROBE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_HOLD   = c_CNT_W'(HOLD_CYCLES);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SETUP  = 2'd1;
   localparam logic [1:0] c_ST_STROBE = 2'd2;
   localparam logic [1:0] c_ST_HOLD   = 2'd3;

   // Entry layout: {write, byte_mode, reg, wdata}
   logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic               w_empty;
   logic               w_full;
   logic               w_accept;
   logic               w_pop;
   logic [c_ENT_W-1:0] w_head;
   logic               w_head_wr;
   logic               w_head_byte;
   logic [REG_W-1:0]   w_head_reg;
   logic [15:0]        w_head_data;

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_wr;
   logic               r_idx;
   logic [7:0]         r_wdata_lo;
   logic [15:0]        r_cap;
   logic               r_rd_pend;
   logic               w_cnt_done;
   logic               w_read_done;

   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign cpu_busy = w_full | r_rd_pend;
   assign w_accept = cpu_req & ~cpu_busy;
   assign w_pop    = (r_state == c_ST_IDLE) & ~w_empty;

   assign w_head      = r_mem[r_rd_ptr[c_AW-1:0]];
   assign w_head_wr   = w_head[c_WR_BIT];
   assign w_head_byte = w_head[c_BY_BIT];
   assign w_head_reg  = w_head[16 +: REG_W];
   assign w_head_data = w_head[15:0];

   assign w_cnt_done  = (r_cnt == c_CNT_ONE);
   // Last byte of a read leaves HOLD here; byte mode starts at index 1.
   assign w_read_done = (r_state == c_ST_HOLD) & w_cnt_done & r_idx & ~r_wr;

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= {cpu_write, cpu_byte, cpu_reg, cpu_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // A read holds off further requests until its data has been returned.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_pend <= 1'b0;
      end else if (w_accept && !cpu_write) begin
         r_rd_pend <= 1'b1;
      end else if (w_read_done) begin
         r_rd_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= c_ST_IDLE;
         r_cnt           <= '0;
         r_wr            <= 1'b0;
         r_idx           <= 1'b0;
         r_wdata_lo      <= 8'h00;
         r_cap           <= 16'h0000;
         bus_cs_n        <= 1'b1;
         bus_rd_nwr      <= 1'b1;
         bus_reg_num     <= '0;
         bus_bytesel     <= 1'b0;
         bus_data_o      <= 8'h00;
         cpu_rdata       <= 16'h0000;
         cpu_rdata_valid <= 1'b0;
      end else begin
         cpu_rdata_valid <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (!w_empty) begin
                  r_wr        <= w_head_wr;
                  r_idx       <= w_head_byte;
                  r_wdata_lo  <= w_head_data[7:0];
                  r_cap       <= 16'h0000;
                  bus_reg_num <= w_head_reg;
                  bus_rd_nwr  <= ~w_head_wr;
                  bus_bytesel <= w_head_byte;
                  if (!w_head_wr) begin
                     bus_data_o <= 8'h00;
                  end else if (w_head_byte) begin
                     bus_data_o <= w_head_data[7:0];
                  end else begin
                     bus_data_o <= w_head_data[15:8];
                  end
                  r_cnt   <= c_CNT_SETUP;
                  r_state <= c_ST_SETUP;
               end
            end
            c_ST_SETUP: begin
               if (w_cnt_done) begin
                  bus_cs_n <= 1'b0;
                  r_cnt    <= c_CNT_STROBE;
                  r_state  <= c_ST_STROBE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            c_ST_STROBE: begin
               if (w_cnt_done) begin
                  if (!r_wr) begin
                     if (r_idx) begin
                        r_cap[7:0] <= bus_data_i;
                     end else begin
                        r_cap[15:8] <= bus_data_i;
                     end
                  end
                  bus_cs_n <= 1'b1;
                  r_cnt    <= c_CNT_HOLD;
                  r_state  <= c_ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            c_ST_HOLD: begin
               if (w_cnt_done) begin
                  if (!r_idx) begin
                     r_idx       <= 1'b1;
                     bus_bytesel <= 1'b1;
                     bus_data_o  <= r_wr ? r_wdata_lo : 8'h00;
                     r_cnt       <= c_CNT_SETUP;
                     r_state     <= c_ST_SETUP;
                  end else begin
                     if (!r_wr) begin
                        cpu_rdata       <= r_cap;
                        cpu_rdata_valid <= 1'b1;
                     end
                     r_state <= c_ST_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
